multicycle_control: RTL
=======================

Name: multicycle_control

Overview:
- Multi-cycle control FSM for the CPU datapath.
- Decodes the latched instruction's opcode/funct and steps through IF, ID, EXE, MEM and WB.
- Drives ALUop/ALUSrcA/ALUSrcB into the ALU, plus the PC, IR, register-file and data-memory enables.
- Consumes the ALU zero/sign flags to resolve branches; sits between the instruction register and every datapath write-enable.

Parameters:
- HALT_OP, 6'h3F, opcode that stops the machine.
- STATE_W, 4, state register width.

Ports:
- CLK  input  1  clock, rising edge.
- Reset  input  1  synchronous, active-high.
- Opcode  input  6  IR[31:26].
- Funct  input  6  IR[5:0].
- Zero  input  1  ALU result == 0.
- Sign  input  1  ALU result negative.
- PCWre  output  1  PC write enable.
- IRWre  output  1  instruction register load.
- RegWre  output  1  register-file write.
- RegDst  output  2  00 rt, 01 rd, 10 $31.
- WrRegDSrc  output  1  0 PC+4 (jal), 1 DB bus.
- DBDataSrc  output  1  0 ALU result, 1 memory data.
- ExtSel  output  1  1 sign-extend, 0 zero-extend.
- ALUSrcA  output  1  1 selects shamt.
- ALUSrcB  output  1  1 selects extended immediate.
- ALUop  output  3  ALU function.
- mRD  output  1  data-memory read.
- mWR  output  1  data-memory write.
- PCSrc  output  2  00 PC+4, 01 branch target, 10 rs (jr), 11 jump target.
- State  output  STATE_W  current state, for debug.

Behaviour:
- State register: sync Reset -> IF (4'd0). All outputs are combinational from State + Opcode/Funct/Zero/Sign.
- In the Reset cycle all enables (PCWre, IRWre, RegWre, mWR, mRD) are 0.
- State codes: IF=0, ID=1, EXE_AL=2, WB_AL=3, EXE_LS=4, MEM=5, WB_LD=6, EXE_BR=7, HALT=8.
- IF:
  - IRWre=1, others idle.
  - Next state ID.
- ID:
  - j (02), jal (03) or R-type funct 08 (jr): PCWre=1, PCSrc=11/11/10, next IF.
  - jal additionally: RegWre=1, RegDst=10, WrRegDSrc=0.
  - Opcode==HALT_OP: PCWre=0, next HALT.
  - lw (23) / sw (2B): next EXE_LS.
  - beq (04), bne (05), bltz (01): next EXE_BR.
  - R-type ALU, addiu (09), andi (0C), ori (0D), xori (0E), slti (0A): next EXE_AL.
  - Any other opcode or funct: treated as nop; PCWre=1, PCSrc=00, next IF.
- EXE_AL: ALU controls asserted, next WB_AL.
- WB_AL:
  - RegWre=1, DBDataSrc=0, WrRegDSrc=1.
  - RegDst=01 for R-type, 00 for immediate forms.
  - PCWre=1, PCSrc=00, next IF.
  - ALU controls stay held in WB_AL.
- EXE_LS: ALUop=000, ALUSrcB=1, ExtSel=1.
  - lw -> MEM.
  - sw -> MEM, with mWR=1 in MEM, PCWre=1, next IF.
- MEM (lw): mRD=1, next WB_LD.
- WB_LD: RegWre=1, DBDataSrc=1, RegDst=00, WrRegDSrc=1, mRD=1, PCWre=1, next IF.
- EXE_BR:
  - ALUop=001, ALUSrcB=0, ExtSel=1, PCWre=1, next IF.
  - PCSrc=01 if taken, else 00.
  - Taken when: beq and Zero; bne and !Zero; bltz and Sign.
- HALT:
  - All enables 0; stays in HALT until Reset.
- ALUop mapping:
  - add/addiu/lw/sw -> 000; sub/branches -> 001; sll -> 010 (ALUSrcA=1).
  - or/ori -> 011; and/andi -> 100; sltu -> 101; slt/slti -> 110; xor/xori -> 111.
- ExtSel: 0 for andi/ori/xori, 1 otherwise.
- Latency in cycles (IF through PC update):
  - j/jal/jr/nop: 2.
  - branch: 3.
  - ALU instruction or sw: 4.
  - lw: 5.
- PCWre is high in exactly one cycle per instruction: the last one.
- Reset in any state, including mid-lw (MEM): next state IF, and no write enable asserts in the Reset cycle.
- Zero/Sign are sampled only in EXE_BR; they are don't-care elsewhere.

Decomposition:
- Shared package cpu_defs holds:
  - opcode and funct constants;
  - ALUop codes (ALU_ADD..ALU_XOR);
  - state encodings;
  - RegDst/PCSrc select encodings.
- One sub-module, alu_decode: combinational Opcode/Funct -> ALUop, ALUSrcA, ALUSrcB, ExtSel, is_rtype_alu. It is instantiated once inside the FSM.

Test Plan:
- Reset held 2 cycles, then released with Opcode=00, Funct=20 -> State sequence 0,1,2,3,0; RegWre=1 and RegDst=01 only in state 3; PCWre=1 only in state 3; ALUop=000.
- lw (Opcode 23) -> states 0,1,4,5,6,0; mRD=1 in states 5-6; RegWre=1 and DBDataSrc=1 in state 6; ALUSrcB=1 in state 4.
- beq with Zero=1 -> 0,1,7,0 and PCSrc=01 in state 7; repeat with Zero=0 -> PCSrc=00. bltz with Sign=1 -> PCSrc=01.
- jal (03) -> 0,1,0; in ID: PCWre=1, PCSrc=11, RegWre=1, RegDst=10, WrRegDSrc=0. sll (Funct 00) -> ALUSrcA=1, ALUop=010.
- Opcode 3F -> enters HALT (8) and stays 20 cycles with all enables 0; Reset -> IF.
- Reset asserted while in MEM of sw -> mWR=0 in that cycle, State=0 next cycle. Undefined opcode 3E -> 2-cycle nop with PCSrc=00.

Source files
------------

// File: rtl/cpu_defs.sv
// Shared definitions for the multi-cycle CPU control path.
// Holds the opcode/funct constants, ALU operation codes, FSM state
// encodings and the RegDst/PCSrc mux select encodings.
package cpu_defs;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BLTZ  = 6'h01;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct codes (IR[5:0])
  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_JR   = 6'h08;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_SLT  = 6'h2A;
  localparam logic [5:0] F_SLTU = 6'h2B;

  // ALU function codes
  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_SLL  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_AND  = 3'b100;
  localparam logic [2:0] ALU_SLTU = 3'b101;
  localparam logic [2:0] ALU_SLT  = 3'b110;
  localparam logic [2:0] ALU_XOR  = 3'b111;

  // FSM state encodings
  localparam logic [3:0] S_IF     = 4'd0;
  localparam logic [3:0] S_ID     = 4'd1;
  localparam logic [3:0] S_EXE_AL = 4'd2;
  localparam logic [3:0] S_WB_AL  = 4'd3;
  localparam logic [3:0] S_EXE_LS = 4'd4;
  localparam logic [3:0] S_MEM    = 4'd5;
  localparam logic [3:0] S_WB_LD  = 4'd6;
  localparam logic [3:0] S_EXE_BR = 4'd7;
  localparam logic [3:0] S_HALT   = 4'd8;

  // RegDst selects
  localparam logic [1:0] RD_RT = 2'b00;
  localparam logic [1:0] RD_RD = 2'b01;
  localparam logic [1:0] RD_RA = 2'b10;

  // PCSrc selects
  localparam logic [1:0] PC_SEQ = 2'b00;
  localparam logic [1:0] PC_BR  = 2'b01;
  localparam logic [1:0] PC_JR  = 2'b10;
  localparam logic [1:0] PC_J   = 2'b11;

endpackage

// File: rtl/alu_decode.sv
// Combinational ALU control decode.
// Ports: opcode/funct in; alu_op, alu_src_a (shamt), alu_src_b (immediate),
// ext_sel (sign-extend) and is_rtype_alu (opcode 0 with an ALU funct) out.
// Memory ops decode to an address add and branches to a compare subtract,
// so the FSM can drive these outputs unchanged in every execute state.
module alu_decode
  import cpu_defs::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [2:0] alu_op,
  output logic       alu_src_a,
  output logic       alu_src_b,
  output logic       ext_sel,
  output logic       is_rtype_alu
);

  always_comb begin
    alu_op       = ALU_ADD;
    alu_src_a    = 1'b0;
    alu_src_b    = 1'b0;
    ext_sel      = 1'b1;
    is_rtype_alu = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        is_rtype_alu = 1'b1;
        case (funct)
          F_ADD:  alu_op = ALU_ADD;
          F_SUB:  alu_op = ALU_SUB;
          F_SLL:  begin alu_op = ALU_SLL; alu_src_a = 1'b1; end
          F_OR:   alu_op = ALU_OR;
          F_AND:  alu_op = ALU_AND;
          F_SLTU: alu_op = ALU_SLTU;
          F_SLT:  alu_op = ALU_SLT;
          F_XOR:  alu_op = ALU_XOR;
          default: is_rtype_alu = 1'b0;
        endcase
      end
      OP_ADDIU: alu_src_b = 1'b1;
      OP_ANDI:  begin alu_op = ALU_AND; alu_src_b = 1'b1; ext_sel = 1'b0; end
      OP_ORI:   begin alu_op = ALU_OR;  alu_src_b = 1'b1; ext_sel = 1'b0; end
      OP_XORI:  begin alu_op = ALU_XOR; alu_src_b = 1'b1; ext_sel = 1'b0; end
      OP_SLTI:  begin alu_op = ALU_SLT; alu_src_b = 1'b1; end
      OP_LW, OP_SW: alu_src_b = 1'b1;
      OP_BEQ, OP_BNE, OP_BLTZ: alu_op = ALU_SUB;
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle CPU control FSM (IF/ID/EXE/MEM/WB).
// Ports: CLK, Reset (sync, active-high), Opcode/Funct from the IR, ALU
// Zero/Sign flags in; PC/IR/register-file/data-memory enables, datapath
// mux selects, ALU controls and the current State (debug) out.
// Outputs are combinational from State and the IR fields; all enables are
// forced low while Reset is high so a reset never commits a write.
module multicycle_control
  import cpu_defs::*;
#(
  parameter logic [5:0] HALT_OP = 6'h3F,
  parameter int         STATE_W = 4
) (
  input  logic               CLK,
  input  logic               Reset,
  input  logic [5:0]         Opcode,
  input  logic [5:0]         Funct,
  input  logic               Zero,
  input  logic               Sign,
  output logic               PCWre,
  output logic               IRWre,
  output logic               RegWre,
  output logic [1:0]         RegDst,
  output logic               WrRegDSrc,
  output logic               DBDataSrc,
  output logic               ExtSel,
  output logic               ALUSrcA,
  output logic               ALUSrcB,
  output logic [2:0]         ALUop,
  output logic               mRD,
  output logic               mWR,
  output logic [1:0]         PCSrc,
  output logic [STATE_W-1:0] State
);

  localparam logic [STATE_W-1:0] ST_IF     = STATE_W'(S_IF);
  localparam logic [STATE_W-1:0] ST_ID     = STATE_W'(S_ID);
  localparam logic [STATE_W-1:0] ST_EXE_AL = STATE_W'(S_EXE_AL);
  localparam logic [STATE_W-1:0] ST_WB_AL  = STATE_W'(S_WB_AL);
  localparam logic [STATE_W-1:0] ST_EXE_LS = STATE_W'(S_EXE_LS);
  localparam logic [STATE_W-1:0] ST_MEM    = STATE_W'(S_MEM);
  localparam logic [STATE_W-1:0] ST_WB_LD  = STATE_W'(S_WB_LD);
  localparam logic [STATE_W-1:0] ST_EXE_BR = STATE_W'(S_EXE_BR);
  localparam logic [STATE_W-1:0] ST_HALT   = STATE_W'(S_HALT);

  logic [STATE_W-1:0] state, nxt;
  logic [2:0] dec_op;
  logic       dec_src_a, dec_src_b, dec_ext, is_r;
  logic       is_imm, is_jr, is_br, taken;
  logic       pc_wre, ir_wre, reg_wre, m_rd, m_wr;

  alu_decode u_dec (
    .opcode       (Opcode),
    .funct        (Funct),
    .alu_op       (dec_op),
    .alu_src_a    (dec_src_a),
    .alu_src_b    (dec_src_b),
    .ext_sel      (dec_ext),
    .is_rtype_alu (is_r)
  );

  assign is_imm = Opcode inside {OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI};
  assign is_jr  = (Opcode == OP_RTYPE) && (Funct == F_JR);
  assign is_br  = Opcode inside {OP_BEQ, OP_BNE, OP_BLTZ};
  assign taken  = ((Opcode == OP_BEQ)  &&  Zero) ||
                  ((Opcode == OP_BNE)  && !Zero) ||
                  ((Opcode == OP_BLTZ) &&  Sign);

  always_ff @(posedge CLK) begin
    if (Reset) state <= ST_IF;
    else       state <= nxt;
  end

  always_comb begin
    nxt       = state;
    pc_wre    = 1'b0;
    ir_wre    = 1'b0;
    reg_wre   = 1'b0;
    m_rd      = 1'b0;
    m_wr      = 1'b0;
    RegDst    = RD_RT;
    WrRegDSrc = 1'b1;
    DBDataSrc = 1'b0;
    ExtSel    = 1'b1;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 1'b0;
    ALUop     = ALU_ADD;
    PCSrc     = PC_SEQ;
    // ALU controls are held from execute through write-back so the ALU
    // result (or memory address) stays stable while it is consumed.
    if (state inside {ST_EXE_AL, ST_WB_AL, ST_EXE_LS, ST_MEM, ST_WB_LD, ST_EXE_BR}) begin
      ALUop   = dec_op;
      ALUSrcA = dec_src_a;
      ALUSrcB = dec_src_b;
      ExtSel  = dec_ext;
    end
    case (state)
      ST_IF: begin
        ir_wre = 1'b1;
        nxt    = ST_ID;
      end
      ST_ID: begin
        nxt = ST_IF;
        if (Opcode == OP_J) begin
          pc_wre = 1'b1;
          PCSrc  = PC_J;
        end else if (Opcode == OP_JAL) begin
          pc_wre    = 1'b1;
          PCSrc     = PC_J;
          reg_wre   = 1'b1;
          RegDst    = RD_RA;
          WrRegDSrc = 1'b0;
        end else if (is_jr) begin
          pc_wre = 1'b1;
          PCSrc  = PC_JR;
        end else if (Opcode == HALT_OP) begin
          nxt = ST_HALT;
        end else if (Opcode == OP_LW || Opcode == OP_SW) begin
          nxt = ST_EXE_LS;
        end else if (is_br) begin
          nxt = ST_EXE_BR;
        end else if (is_r || is_imm) begin
          nxt = ST_EXE_AL;
        end else begin
          pc_wre = 1'b1;  // unknown encoding retires as a nop
        end
      end
      ST_EXE_AL: nxt = ST_WB_AL;
      ST_WB_AL: begin
        reg_wre = 1'b1;
        RegDst  = is_r ? RD_RD : RD_RT;
        pc_wre  = 1'b1;
        nxt     = ST_IF;
      end
      ST_EXE_LS: nxt = ST_MEM;
      ST_MEM: begin
        if (Opcode == OP_SW) begin
          m_wr   = 1'b1;
          pc_wre = 1'b1;
          nxt    = ST_IF;
        end else begin
          m_rd = 1'b1;
          nxt  = ST_WB_LD;
        end
      end
      ST_WB_LD: begin
        reg_wre   = 1'b1;
        DBDataSrc = 1'b1;
        m_rd      = 1'b1;
        pc_wre    = 1'b1;
        nxt       = ST_IF;
      end
      ST_EXE_BR: begin
        pc_wre = 1'b1;
        PCSrc  = taken ? PC_BR : PC_SEQ;
        nxt    = ST_IF;
      end
      ST_HALT: nxt = ST_HALT;
      default: nxt = ST_IF;  // unused codes recover to fetch
    endcase
  end

  assign PCWre  = pc_wre  & ~Reset;
  assign IRWre  = ir_wre  & ~Reset;
  assign RegWre = reg_wre & ~Reset;
  assign mRD    = m_rd    & ~Reset;
  assign mWR    = m_wr    & ~Reset;
  assign State  = state;

endmodule
